// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: round-robin with a line-fill lock, plus an in-order
// read-ID FIFO that routes each memory response back to the issuing cache.
module mem_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LOCK_BEATS   = 4,
  parameter int unsigned IDLE_TIMEOUT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_c0_mem_ren,
  input  logic        i_c0_mem_wen,
  input  logic [31:0] i_c0_mem_addr,
  input  logic [31:0] i_c0_mem_wdata,
  output logic        o_c0_mem_ready,
  output logic [31:0] o_c0_mem_rdata,
  output logic        o_c0_mem_valid,
  input  logic        i_c1_mem_ren,
  input  logic        i_c1_mem_wen,
  input  logic [31:0] i_c1_mem_addr,
  input  logic [31:0] i_c1_mem_wdata,
  output logic        o_c1_mem_ready,
  output logic [31:0] o_c1_mem_rdata,
  output logic        o_c1_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(LOCK_BEATS + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BEATS_MAX = BW'(LOCK_BEATS);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  typedef enum logic {
    PORT_C0 = 1'b0,
    PORT_C1 = 1'b1
  } port_e;

  logic          lock_q, lock_d;
  port_e         owner_q, owner_d;
  port_e         rr_q, rr_d;
  logic [BW-1:0] beats_q, beats_d, beats_inc;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          err_q, err_d;
  port_e         id_q [FIFO_DEPTH];

  logic        req0, req1, owner_req;
  logic        gnt_vld;
  port_e       gnt_id;
  logic        sel_ren, sel_wen, rd_blocked;
  logic [31:0] sel_addr, sel_wdata;
  logic        fifo_empty, fifo_full;
  logic        accept, push, pop;
  port_e       head;
  logic        head_c0, head_c1;

  assign req0      = i_c0_mem_ren | i_c0_mem_wen;
  assign req1      = i_c1_mem_ren | i_c1_mem_wen;
  assign owner_req = (owner_q == PORT_C1) ? req1 : req0;

  // Under the lock only the owner may be granted; an idle owner stalls the
  // other port until the idle timeout releases the lock.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = PORT_C0;
    if (!i_rst) begin
      if (lock_q) begin
        if (owner_req) begin
          gnt_vld = 1'b1;
          gnt_id  = owner_q;
        end
      end else if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_id  = PORT_C0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_id  = PORT_C1;
      end
    end
  end

  assign sel_ren   = (gnt_id == PORT_C1) ? i_c1_mem_ren   : i_c0_mem_ren;
  assign sel_wen   = (gnt_id == PORT_C1) ? i_c1_mem_wen   : i_c0_mem_wen;
  assign sel_addr  = (gnt_id == PORT_C1) ? i_c1_mem_addr  : i_c0_mem_addr;
  assign sel_wdata = (gnt_id == PORT_C1) ? i_c1_mem_wdata : i_c0_mem_wdata;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_blocked = sel_ren & fifo_full;

  assign o_mem_ren   = gnt_vld & sel_ren & ~fifo_full;
  assign o_mem_wen   = gnt_vld & sel_wen & ~rd_blocked;
  assign o_mem_addr  = gnt_vld ? sel_addr  : '0;
  assign o_mem_wdata = gnt_vld ? sel_wdata : '0;

  assign o_c0_mem_ready = i_mem_ready & gnt_vld & (gnt_id == PORT_C0) & ~(i_c0_mem_ren & fifo_full);
  assign o_c1_mem_ready = i_mem_ready & gnt_vld & (gnt_id == PORT_C1) & ~(i_c1_mem_ren & fifo_full);

  assign accept = (o_mem_ren | o_mem_wen) & i_mem_ready;
  assign push   = o_mem_ren & i_mem_ready;
  assign pop    = i_mem_valid & ~fifo_empty;

  assign head    = id_q[rptr_q[AW-1:0]];
  assign head_c0 = ~fifo_empty & (head == PORT_C0);
  assign head_c1 = ~fifo_empty & (head == PORT_C1);

  assign o_c0_mem_valid = i_mem_valid & head_c0;
  assign o_c1_mem_valid = i_mem_valid & head_c1;
  assign o_c0_mem_rdata = head_c0 ? i_mem_rdata : '0;
  assign o_c1_mem_rdata = head_c1 ? i_mem_rdata : '0;
  assign o_err          = err_q;

  assign beats_inc = (beats_q == BEATS_MAX) ? beats_q : beats_q + BW'(1);
  assign idle_inc  = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    beats_d = beats_q;
    idle_d  = idle_q;
    rr_d    = rr_q;
    wptr_d  = wptr_q + {{AW{1'b0}}, push};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    err_d   = err_q | (i_mem_valid & fifo_empty);
    if (accept) begin
      rr_d = (gnt_id == PORT_C0) ? PORT_C1 : PORT_C0;
    end
    if (!lock_q) begin
      if (push) begin
        owner_d = gnt_id;
        beats_d = BW'(1);
        idle_d  = '0;
        lock_d  = (BEATS_MAX != BW'(1));
      end
    end else if (owner_req) begin
      idle_d = '0;
      if (push) begin
        beats_d = beats_inc;
        if (beats_inc == BEATS_MAX) lock_d = 1'b0;
      end
    end else begin
      idle_d = idle_inc;
      if (idle_inc == IDLE_MAX) lock_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_q  <= 1'b0;
      owner_q <= PORT_C0;
      rr_q    <= PORT_C0;
      beats_q <= '0;
      idle_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
      idle_q  <= idle_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) id_q[wptr_q[AW-1:0]] <= gnt_id;
  end

endmodule
